// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Two-requester arbiter in front of a single-ported word memory.
//   A winner is picked in IDLE and its command is registered. ACCESS then
//   drives the memory for WAIT_STATES+1 cycles. RESP pulses the winner's ack
//   for one cycle, and the FSM returns to IDLE.
//
//   Optional feature: define ARB_ROUND_ROBIN_EN to alternate grants between
//   simultaneous requesters. Without it, requester 0 always wins contention.
//
// Parameters
//   WAIT_STATES  extra memory cycles per access (0..15)
// Ports
//   clk, rst                         clock, synchronous active-high reset
//   req0/we0/addr0/wdata0            requester 0 command (held until ack0)
//   ack0, rdata0                     requester 0 completion pulse, read data
//   req1/we1/addr1/wdata1            requester 1 command (held until ack1)
//   ack1, rdata1                     requester 1 completion pulse, read data
//   mem_en, mem_we                   memory access / write strobes
//   mem_addr, mem_wdata              memory address / write data
//   mem_rdata                        memory read data (valid in final ACCESS)
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0,
    input  logic        we0,
    input  logic [15:0] addr0,
    input  logic [15:0] wdata0,
    output logic        ack0,
    output logic [15:0] rdata0,
    input  logic        req1,
    input  logic        we1,
    input  logic [15:0] addr1,
    input  logic [15:0] wdata1,
    output logic        ack1,
    output logic [15:0] rdata1,
    output logic        mem_en,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state, state_nx;
    logic [3:0]  cnt;
    logic        sel;       // registered winner: 0 = requester 0, 1 = requester 1
    logic        we_r;
    logic [15:0] addr_r, wdata_r, rdata0_r, rdata1_r;
    logic        any_req, win, last_beat;

    assign any_req   = req0 | req1;
    assign last_beat = (cnt == WS);

`ifdef ARB_ROUND_ROBIN_EN
    // last = requester granted most recently. It resets to 1, so requester 0
    // wins the first contention after reset.
    logic last;

    always_comb begin
        if (req0 && req1) win = ~last;
        else              win = ~req0;
    end

    always_ff @(posedge clk) begin
        if (rst)                           last <= 1'b1;
        else if (state == IDLE && any_req) last <= win;
    end
`else
    // Fixed priority: requester 1 is granted only when requester 0 is idle.
    always_comb win = ~req0;
`endif

    // Next-state and strobe decode
    always_comb begin
        state_nx = state;
        mem_en   = 1'b0;
        ack0     = 1'b0;
        ack1     = 1'b0;
        case (state)
            IDLE:   if (any_req) state_nx = ACCESS;
            ACCESS: begin
                mem_en = 1'b1;
                if (last_beat) state_nx = RESP;
            end
            RESP: begin
                ack0     = ~sel;
                ack1     = sel;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign mem_we    = mem_en & we_r;
    assign mem_addr  = addr_r;
    assign mem_wdata = wdata_r;
    assign rdata0    = rdata0_r;
    assign rdata1    = rdata1_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            sel      <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (any_req) begin
                    // Capture the command once. Later changes on the inputs
                    // are ignored until the FSM is back in IDLE.
                    sel     <= win;
                    we_r    <= win ? we1 : we0;
                    addr_r  <= win ? addr1 : addr0;
                    wdata_r <= win ? wdata1 : wdata0;
                    cnt     <= '0;
                end
                ACCESS: begin
                    if (last_beat) begin
                        if (!we_r) begin
                            if (sel) rdata1_r <= mem_rdata;
                            else     rdata0_r <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. The main instance uses WAIT_STATES=1. A
//   second instance with WAIT_STATES=0 covers the back-to-back
//   single-cycle-access case. Inputs change on the falling edge, and outputs
//   are sampled on the falling edge.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, we0, req1, we1;
    logic [15:0] addr0, wdata0, addr1, wdata1;
    logic        ack0, ack1, mem_en, mem_we;
    logic [15:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

    // WAIT_STATES=0 instance; its memory returns addr ^ 0xA000.
    logic        z_req0, z_ack0, z_ack1, z_mem_en, z_mem_we;
    logic [15:0] z_addr0, z_rdata0, z_rdata1, z_mem_addr, z_mem_wdata, z_mem_rdata;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.WAIT_STATES(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0),
        .ack0(ack0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1),
        .ack1(ack1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    assign z_mem_rdata = z_mem_addr ^ 16'hA000;

    mem_arbiter #(.WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst),
        .req0(z_req0), .we0(1'b0), .addr0(z_addr0), .wdata0(16'h0000),
        .ack0(z_ack0), .rdata0(z_rdata0),
        .req1(1'b0), .we1(1'b0), .addr1(16'h0000), .wdata1(16'h0000),
        .ack1(z_ack1), .rdata1(z_rdata1),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr),
        .mem_wdata(z_mem_wdata), .mem_rdata(z_mem_rdata)
    );

    task automatic test_reset();
        rst = 1'b1;
        req0 = 0; we0 = 0; addr0 = 0; wdata0 = 0;
        req1 = 0; we1 = 0; addr1 = 0; wdata1 = 0;
        mem_rdata = 0; z_req0 = 0; z_addr0 = 0;
        repeat (3) @(negedge clk);
        total++;
        if ({ack0, ack1, mem_en, mem_we} !== 4'b0000) begin
            bad++; $display("FAIL reset_strobes got=%b want=0000", {ack0, ack1, mem_en, mem_we});
        end
        total++;
        if ({mem_addr, mem_wdata, rdata0, rdata1} !== 64'h0) begin
            bad++; $display("FAIL reset_regs got=%h want=0", {mem_addr, mem_wdata, rdata0, rdata1});
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    // Requester 0 reads 0x0010. Its inputs change mid-access to check they
    // are ignored.
    task automatic test_read();
        int en_n = 0, a0_n = 0, a1_n = 0, ack_cyc = -1, we_n = 0;
        logic addr_ok = 1'b1;
        req0 = 1; we0 = 0; addr0 = 16'h0010; mem_rdata = 16'hBEEF;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_en) begin
                en_n++;
                if (mem_addr !== 16'h0010) addr_ok = 1'b0;
            end
            if (mem_we) we_n++;
            if (ack1) a1_n++;
            if (ack0) begin a0_n++; ack_cyc = c; req0 = 0; end
            if (c == 1) begin addr0 = 16'hFFFF; we0 = 1; end
        end
        we0 = 0;
        total++; if (en_n != 2) begin bad++; $display("FAIL read_en_cycles got=%0d want=2", en_n); end
        total++; if (a0_n != 1) begin bad++; $display("FAIL read_ack0_pulses got=%0d want=1", a0_n); end
        total++; if (ack_cyc != 3) begin bad++; $display("FAIL read_latency got=%0d want=3", ack_cyc); end
        total++; if (rdata0 !== 16'hBEEF) begin bad++; $display("FAIL read_rdata0 got=%h want=beef", rdata0); end
        total++; if (a1_n != 0) begin bad++; $display("FAIL read_ack1 got=%0d want=0", a1_n); end
        total++; if (!addr_ok || we_n != 0) begin bad++; $display("FAIL read_ignore_change addr_ok=%b we_cycles=%0d want 1/0", addr_ok, we_n); end
    endtask

    // Requester 1 writes 0x1234 to 0x0200. The memory's read data must not
    // leak into either rdata register.
    task automatic test_write();
        int we_n = 0, a1_n = 0;
        logic bus_ok = 1'b1;
        req1 = 1; we1 = 1; addr1 = 16'h0200; wdata1 = 16'h1234; mem_rdata = 16'hDEAD;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (mem_we) begin
                we_n++;
                if (mem_addr !== 16'h0200 || mem_wdata !== 16'h1234) bus_ok = 1'b0;
            end
            if (ack0) bus_ok = 1'b0;
            if (ack1) begin a1_n++; req1 = 0; end
        end
        we1 = 0;
        total++; if (we_n != 2) begin bad++; $display("FAIL write_we_cycles got=%0d want=2", we_n); end
        total++; if (!bus_ok) begin bad++; $display("FAIL write_bus addr=%h wdata=%h want 0200/1234", mem_addr, mem_wdata); end
        total++; if (a1_n != 1) begin bad++; $display("FAIL write_ack1_pulses got=%0d want=1", a1_n); end
        total++; if (rdata1 !== 16'h0000 || rdata0 !== 16'hBEEF) begin
            bad++; $display("FAIL write_rdata_hold got=%h/%h want 0000/beef", rdata1, rdata0);
        end
        total++; if (mem_addr !== 16'h0200 || mem_en !== 1'b0) begin
            bad++; $display("FAIL write_addr_hold got=%h en=%b want=0200/0", mem_addr, mem_en);
        end
    endtask

    // Both requesters stay high for four grants.
    task automatic test_contention();
        logic [3:0] order = 4'b0;
        logic [3:0] want;
        int n = 0;
        logic both = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        want = 4'b1010;   // bit i = winner of grant i: 0,1,0,1
`else
        want = 4'b0000;
`endif
        req0 = 1; req1 = 1; addr0 = 16'h0030; addr1 = 16'h0040; mem_rdata = 16'h5555;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (ack0 && ack1) both = 1'b1;
            if (ack0 || ack1) begin order[n] = ack1; n++; end
        end
        req0 = 0; req1 = 0;
        repeat (4) @(negedge clk);
        total++; if (n != 4) begin bad++; $display("FAIL contention_timeout grants=%0d want=4", n); end
        total++; if (order !== want) begin bad++; $display("FAIL contention_order got=%b want=%b", order, want); end
        total++; if (both) begin bad++; $display("FAIL contention_dual_ack got=1 want=0"); end
    endtask

    // Reset lands on the second ACCESS cycle of a read. The held request is
    // then serviced again from scratch.
    task automatic test_reset_mid();
        int a_n = 0, a_cyc = -1;
        req0 = 1; we0 = 0; addr0 = 16'h0077; mem_rdata = 16'h7777;
        @(negedge clk);            // first ACCESS cycle
        @(negedge clk);            // second ACCESS cycle
        rst = 1'b1;
        @(negedge clk);
        total++; if (mem_en !== 1'b0 || ack0 !== 1'b0) begin
            bad++; $display("FAIL rstmid_abort en=%b ack0=%b want 0/0", mem_en, ack0);
        end
        rst = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (ack0) begin a_n++; a_cyc = c; req0 = 0; end
        end
        total++; if (a_n != 1 || a_cyc != 3) begin
            bad++; $display("FAIL rstmid_reissue acks=%0d cyc=%0d want 1/3", a_n, a_cyc);
        end
        total++; if (rdata0 !== 16'h7777) begin bad++; $display("FAIL rstmid_rdata got=%h want=7777", rdata0); end
    endtask

    // WAIT_STATES=0: two reads issued back to back from a held req0.
    task automatic test_back_to_back();
        int en_n = 0, a_n = 0;
        int a_cyc [2] = '{-1, -1};
        logic [15:0] rd [2] = '{16'h0, 16'h0};
        logic [15:0] ea [2] = '{16'h0, 16'h0};
        z_req0 = 1; z_addr0 = 16'h0001;
        for (int c = 1; c <= 9; c++) begin
            @(negedge clk);
            if (z_mem_en) begin
                if (en_n < 2) ea[en_n] = z_mem_addr;
                en_n++;
            end
            if (z_ack0) begin
                if (a_n < 2) begin a_cyc[a_n] = c; rd[a_n] = z_rdata0; end
                a_n++;
                z_addr0 = 16'h0002;
                if (a_n == 2) z_req0 = 0;
            end
        end
        total++; if (en_n != 2 || ea[0] !== 16'h0001 || ea[1] !== 16'h0002) begin
            bad++; $display("FAIL b2b_access en=%0d addr=%h,%h want 2/0001,0002", en_n, ea[0], ea[1]);
        end
        total++; if (a_n != 2 || a_cyc[0] != 2 || a_cyc[1] != 5) begin
            bad++; $display("FAIL b2b_ack_spacing acks=%0d at %0d,%0d want 2 at 2,5", a_n, a_cyc[0], a_cyc[1]);
        end
        total++; if (rd[0] !== 16'hA001 || rd[1] !== 16'hA002) begin
            bad++; $display("FAIL b2b_rdata got=%h,%h want a001,a002", rd[0], rd[1]);
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_write();
        test_contention();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 WAIT_STATES, 1, extra memory cycles added to each access (legal 0..15).
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0  input  1  requester 0 (CPU fetch/data) access request, held high until ack0.
REQ-005 we0  input  1  requester 0 write enable (1 = write, 0 = read).
REQ-006 addr0  input  16  requester 0 word address.
REQ-007 wdata0  input  16  requester 0 write data.
REQ-008 ack0  output  1  requester 0 completion pulse.
REQ-009 rdata0  output  16  requester 0 read data, valid when ack0 is high.
REQ-010 req1  input  1  requester 1 (loader/debug) access request, held high until ack1.
REQ-011 we1  input  1  requester 1 write enable.
REQ-012 addr1  input  16  requester 1 word address.
REQ-013 wdata1  input  16  requester 1 write data.
REQ-014 ack1  output  1  requester 1 completion pulse.
REQ-015 rdata1  output  16  requester 1 read data, valid when ack1 is high.
REQ-016 mem_en  output  1  memory access strobe.
REQ-017 mem_we  output  1  memory write strobe.
REQ-018 mem_addr  output  16  memory word address.
REQ-019 mem_wdata  output  16  memory write data.
REQ-020 mem_rdata  input  16  memory read data, valid during the final ACCESS cycle.

Function
REQ-021 The FSM SHALL have exactly three states: IDLE, ACCESS and RESP.
REQ-022 In IDLE, requests SHALL be sampled; if any are high, the block SHALL pick a winner, register its we/addr/wdata, and enter ACCESS on the next edge.
REQ-023 In ACCESS, mem_en SHALL be 1 and mem_we SHALL equal the registered we, for exactly WAIT_STATES+1 cycles counted by a 4-bit counter.
REQ-024 On the final ACCESS edge, a read SHALL capture mem_rdata into the winner's rdata register and enter RESP; a write SHALL leave both rdata registers unchanged.
REQ-025 In RESP, the winner's ack SHALL be 1 for exactly one cycle with mem_en=0; the next state SHALL be IDLE.
REQ-026 Latency: with req sampled at edge E, ack SHALL be high in the cycle after edge E+WAIT_STATES+1 (3 cycles from request to ack for WAIT_STATES=1).
REQ-027 Requests SHALL NOT be sampled in ACCESS or RESP; changes to req/addr/wdata/we during an access SHALL be ignored.
REQ-028 A requester that still holds req in the IDLE cycle after its ack SHALL be treated as a new request.
REQ-029 ack0 and ack1 SHALL never be high in the same cycle.
REQ-030 An ack SHALL never be issued without a sampled request.
REQ-031 mem_we SHALL be 0 whenever mem_en is 0.
REQ-032 mem_addr/mem_wdata SHALL hold their last registered values outside ACCESS.
REQ-033 rdataN SHALL hold its value until the next read completion by requester N.
REQ-034 If only one requester is active, it SHALL win regardless of arbitration history.
REQ-035 WAIT_STATES=0 SHALL give a single ACCESS cycle.

Reset
REQ-036 Reset SHALL force IDLE, wait counter 0, ack0=ack1=0, mem_en=mem_we=0, mem_addr=mem_wdata=0, rdata0=rdata1=0, and last-grant pointer=1.
REQ-037 Reset asserted mid-ACCESS or mid-RESP SHALL abort the access with no ack issued; mem_en SHALL be 0 in the first cycle after the reset edge.

Configuration
REQ-038 With ARB_ROUND_ROBIN_EN defined, simultaneous requests SHALL be granted to the requester not granted last, and the pointer SHALL update on every grant (requester 0 wins the first contention after reset).
REQ-039 With ARB_ROUND_ROBIN_EN undefined, requester 0 SHALL always win simultaneous requests; starvation of requester 1 is accepted and the pointer logic SHALL be absent.

Verification
REQ-040 WAIT_STATES=1, req0 read addr 0x0010, mem_rdata=0xBEEF -> mem_en high 2 cycles, ack0 pulses once, rdata0=0xBEEF, ack1 stays 0.
REQ-041 req1 write addr 0x0200 data 0x1234 -> mem_we=1 for 2 cycles with mem_addr=0x0200 and mem_wdata=0x1234, ack1 pulses, rdata1 unchanged.
REQ-042 req0 and req1 both held high for 4 accesses, round-robin build -> grant order 0,1,0,1; fixed-priority build -> 0,0,0,0.
REQ-043 rst pulsed on the second ACCESS cycle of a read -> no ack, mem_en=0 the next cycle, the re-issued request completes normally.
REQ-044 WAIT_STATES=0, back-to-back req0 reads of 0x0001 then 0x0002 -> each access has 1 mem_en cycle, ack spacing is 3 cycles, and no overlapping acks.
